// File: rtl/alu_share_arbiter.sv
// Round-robin share of one registered ALU between two requesters.
// One operation in flight; result returned on a valid/ready channel.
module alu_share_arbiter #(
   parameter int WIDTH = 32,
   parameter int TAGW  = 4
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [4:0]       req0_sel,
   input  logic [TAGW-1:0]  req0_tag,

   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [4:0]       req1_sel,
   input  logic [TAGW-1:0]  req1_tag,

   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [4:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,

   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [TAGW-1:0]  resp_tag,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_zero,
   output logic             resp_err
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      CAPT,
      RESP
   } state_e;

   localparam logic [4:0] SEL_MAX  = 5'h10;
   localparam logic [4:0] SEL_DIV  = 5'h04;
   localparam logic [4:0] SEL_REM  = 5'h05;

   state_e           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [4:0]       sel_q, sel_d;
   logic [TAGW-1:0]  tag_q, tag_d;
   logic             id_q, id_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             zero_q, zero_d;
   logic             err_q, err_d;

   logic             gnt0, gnt1, accept;
   logic [WIDTH-1:0] win_a, win_b;
   logic [4:0]       win_sel;
   logic [TAGW-1:0]  win_tag;
   logic             op_err;

   // Grants are gated by reset so ready is low while rst is held.
   always_comb begin
      gnt0 = rst && (state_q == IDLE) && req0_valid
             && (!req1_valid || !ptr_q);
      gnt1 = rst && (state_q == IDLE) && req1_valid
             && (!req0_valid || ptr_q);
      accept = gnt0 || gnt1;
   end

   always_comb begin
      win_a   = gnt1 ? req1_a   : req0_a;
      win_b   = gnt1 ? req1_b   : req0_b;
      win_sel = gnt1 ? req1_sel : req0_sel;
      win_tag = gnt1 ? req1_tag : req0_tag;
      op_err  = (win_sel > SEL_MAX)
                || (((win_sel == SEL_DIV) || (win_sel == SEL_REM))
                    && (win_b == '0));
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      a_d     = a_q;
      b_d     = b_q;
      sel_d   = sel_q;
      tag_d   = tag_q;
      id_d    = id_q;
      data_d  = data_q;
      zero_d  = zero_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               a_d   = win_a;
               b_d   = win_b;
               sel_d = win_sel;
               tag_d = win_tag;
               id_d  = gnt1;
               ptr_d = ~gnt1;
               if (op_err) begin
                  data_d  = '0;
                  zero_d  = 1'b0;
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  state_d = EXEC;
               end
            end
         end
         EXEC: state_d = CAPT;
         CAPT: begin
            data_d  = alu_result;
            zero_d  = alu_zero;
            err_d   = 1'b0;
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sel_q   <= '0;
         tag_q   <= '0;
         id_q    <= 1'b0;
         data_q  <= '0;
         zero_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sel_q   <= sel_d;
         tag_q   <= tag_d;
         id_q    <= id_d;
         data_q  <= data_d;
         zero_q  <= zero_d;
         err_q   <= err_d;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign alu_a      = a_q;
   assign alu_b      = b_q;
   assign alu_sel    = sel_q;
   assign resp_valid = (state_q == RESP);
   assign resp_id    = id_q;
   assign resp_tag   = tag_q;
   assign resp_data  = data_q;
   assign resp_zero  = zero_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: random requesters, ALU model,
// response scoreboard with latency and arbitration model.
module tb_alu_share_arbiter;

   localparam int W = 32;
   localparam int T = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req0_valid, req0_ready;
   logic [W-1:0]  req0_a, req0_b;
   logic [4:0]    req0_sel;
   logic [T-1:0]  req0_tag;
   logic          req1_valid, req1_ready;
   logic [W-1:0]  req1_a, req1_b;
   logic [4:0]    req1_sel;
   logic [T-1:0]  req1_tag;
   logic [W-1:0]  alu_a, alu_b;
   logic [4:0]    alu_sel;
   logic [W-1:0]  alu_result = '0;
   logic          alu_zero = 1'b0;
   logic          resp_valid, resp_ready;
   logic          resp_id;
   logic [T-1:0]  resp_tag;
   logic [W-1:0]  resp_data;
   logic          resp_zero, resp_err;

   always #5 clk = ~clk;

   alu_share_arbiter #(.WIDTH(W), .TAGW(T)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b),
      .req0_sel(req0_sel), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b),
      .req1_sel(req1_sel), .req1_tag(req1_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_tag(resp_tag),
      .resp_data(resp_data), .resp_zero(resp_zero),
      .resp_err(resp_err)
   );

   function automatic logic [W-1:0] alu_fn(
      input logic [W-1:0] a,
      input logic [W-1:0] b,
      input logic [4:0]   s
   );
      logic [W-1:0] r;
      case (s)
         5'h00: r = a;
         5'h01: r = b;
         5'h02: r = a << b[4:0];
         5'h03: r = a >> b[4:0];
         5'h04: r = (b == 0) ? '1 : a / b;
         5'h05: r = (b == 0) ? a : a % b;
         5'h06: r = a + b;
         5'h07: r = a * b;
         5'h08: r = a - b;
         5'h09: r = a ^ b;
         5'h0A: r = a & b;
         5'h0B: r = a | b;
         5'h0C: r = W'($signed(a) >>> b[4:0]);
         5'h0D: r = ~(a | b);
         5'h0E: r = {31'd0, ($signed(a) < $signed(b))};
         5'h0F: r = {31'd0, (a < b)};
         5'h10: r = b;
         default: r = 32'hDEAD_BEEF;
      endcase
      return r;
   endfunction

   // External registered ALU
   always @(posedge clk) begin
      alu_result <= alu_fn(alu_a, alu_b, alu_sel);
      alu_zero   <= (alu_a == alu_b);
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit           id;
      logic [T-1:0] tag;
      logic [W-1:0] data;
      bit           zero;
      bit           err;
      int           acc;
   } exp_t;

   exp_t q[$];

   int n_chk = 0;
   int n_pass = 0;
   int acc_cnt = 0;
   int hs_cnt = 0;
   int last_hs = 0;
   bit mptr = 1'b0;
   int bp_hold = 0;
   bit seen = 1'b0;

   bit           pend [2];
   logic [W-1:0] pa [2];
   logic [W-1:0] pb [2];
   logic [4:0]   ps [2];
   logic [T-1:0] pt [2];

   task automatic chk(input bit ok, input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h @cyc %0d",
                    nm, act, exp, cyc);
   endtask

   // Scoreboard monitor
   initial begin
      exp_t e;
      bit   ok;
      resp_ready = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            resp_ready = 1'b0;
            seen = 1'b0;
         end else if (resp_valid) begin
            if (q.size() == 0) begin
               chk(1'b0, "spurious_resp", 64'(resp_data), 64'(0));
               resp_ready = 1'b1;
            end else begin
               e = q[0];
               if (!seen) begin
                  chk((cyc - e.acc) == (e.err ? 1 : 3), "latency",
                      64'(cyc - e.acc), 64'(e.err ? 1 : 3));
                  seen = 1'b1;
               end
               ok = {resp_id, resp_tag, resp_data, resp_zero, resp_err}
                    == {e.id, e.tag, e.data, e.zero, e.err};
               chk(ok, "resp",
                   64'({resp_id, resp_tag, resp_data,
                        resp_zero, resp_err}),
                   64'({e.id, e.tag, e.data, e.zero, e.err}));
               if (bp_hold > 0) begin
                  bp_hold--;
                  resp_ready = 1'b0;
               end else begin
                  resp_ready = ($urandom_range(0, 3) != 0);
               end
               if (resp_ready) begin
                  void'(q.pop_front());
                  hs_cnt++;
                  last_hs = cyc + 1;
                  seen = 1'b0;
               end
            end
         end else begin
            resp_ready = 1'($urandom_range(0, 1));
         end
      end
   end

   task automatic set_op(input int r, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] s,
                         input logic [T-1:0] t);
      pend[r] = 1'b1;
      pa[r] = a;
      pb[r] = b;
      ps[r] = s;
      pt[r] = t;
   endtask

   task automatic rand_op(input int r);
      logic [W-1:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      set_op(r, a, b, 5'($urandom_range(0, 19)), T'($urandom));
   endtask

   task automatic step(input bit gen);
      bit   idle, any, w, err;
      exp_t e;
      @(negedge clk);
      #2;
      if (gen) begin
         for (int r = 0; r < 2; r++) begin
            if (pend[r] && $urandom_range(0, 15) == 0) pend[r] = 1'b0;
            else if (!pend[r] && $urandom_range(0, 1) == 1) rand_op(r);
         end
      end
      req0_valid = pend[0];
      req0_a   = pend[0] ? pa[0] : W'($urandom);
      req0_b   = pend[0] ? pb[0] : W'($urandom);
      req0_sel = pend[0] ? ps[0] : 5'($urandom);
      req0_tag = pend[0] ? pt[0] : T'($urandom);
      req1_valid = pend[1];
      req1_a   = pend[1] ? pa[1] : W'($urandom);
      req1_b   = pend[1] ? pb[1] : W'($urandom);
      req1_sel = pend[1] ? ps[1] : 5'($urandom);
      req1_tag = pend[1] ? pt[1] : T'($urandom);
      #1;
      idle = (acc_cnt == hs_cnt) && (last_hs <= cyc);
      any  = idle && (pend[0] || pend[1]);
      w    = (pend[0] && pend[1]) ? mptr : pend[1];
      chk(req0_ready == (any && !w), "req0_ready",
          64'(req0_ready), 64'(any && !w));
      chk(req1_ready == (any && w), "req1_ready",
          64'(req1_ready), 64'(any && w));
      if (any) begin
         err = (ps[w] > 5'h10)
               || ((ps[w] == 5'h04 || ps[w] == 5'h05) && pb[w] == 0);
         e.id   = w;
         e.tag  = pt[w];
         e.err  = err;
         e.data = err ? '0 : alu_fn(pa[w], pb[w], ps[w]);
         e.zero = err ? 1'b0 : (pa[w] == pb[w]);
         e.acc  = cyc;
         q.push_back(e);
         acc_cnt++;
         mptr = !w;
         pend[w] = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((pend[0] || pend[1] || acc_cnt != hs_cnt) && n < 300) begin
         step(1'b0);
         n++;
      end
      if (n >= 300) chk(1'b0, "drain_timeout", 64'(n), 64'(300));
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({req0_ready, req1_ready} == 2'b00, {nm, "_ready"},
          64'({req0_ready, req1_ready}), 64'(0));
      chk({alu_a, alu_b, alu_sel} == '0, {nm, "_alu"},
          64'({alu_a, alu_sel}), 64'(0));
      chk({resp_valid, resp_id, resp_tag, resp_data,
           resp_zero, resp_err} == '0, {nm, "_resp"},
          64'({resp_valid, resp_id, resp_tag, resp_data,
               resp_zero, resp_err}), 64'(0));
   endtask

   initial begin
      int a0, n;
      #2_000_000;
      $display("FAIL watchdog: simulation did not end, got %0d expected 0",
               cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a0, n;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 32'h11; req0_b = 32'h22; req0_sel = 5'h06; req0_tag = 4'h1;
      req1_a = 32'h33; req1_b = 32'h44; req1_sel = 5'h06; req1_tag = 4'h2;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk_reset_outs("reset");
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #1;
      rst = 1'b1;

      // contention from reset, then alternation
      set_op(0, 32'd10, 32'd4, 5'h08, 4'h1);
      set_op(1, 32'd6, 32'd3, 5'h0A, 4'h2);
      drain();
      set_op(0, 32'd20, 32'd1, 5'h08, 4'h3);
      set_op(1, 32'd7, 32'd5, 5'h0A, 4'h4);
      drain();

      set_op(0, 32'd5, 32'd7, 5'h06, 4'h3);
      drain();
      set_op(1, 32'd9, 32'd0, 5'h04, 4'h5);
      drain();
      set_op(1, 32'd9, 32'd3, 5'h04, 4'h6);
      drain();
      set_op(0, 32'd1, 32'd2, 5'h11, 4'h7);
      drain();
      set_op(0, 32'hFFFF_FFFF, 32'd1, 5'h0E, 4'h8);
      drain();
      set_op(1, 32'h55, 32'h55, 5'h0B, 4'h9);
      drain();

      // backpressure with the other requester pending
      bp_hold = 5;
      set_op(0, 32'd100, 32'd23, 5'h06, 4'hA);
      set_op(1, 32'd100, 32'd23, 5'h08, 4'hB);
      drain();

      repeat (400) step(1'b1);
      drain();

      // asynchronous reset during EXEC
      set_op(0, 32'h100, 32'h23, 5'h06, 4'hC);
      a0 = acc_cnt;
      n = 0;
      while (acc_cnt == a0 && n < 100) begin
         step(1'b0);
         n++;
      end
      if (n >= 100) chk(1'b0, "accept_timeout", 64'(n), 64'(100));
      @(posedge clk);
      #2;
      rst = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk_reset_outs("midop_reset");
      q.delete();
      hs_cnt = acc_cnt;
      last_hs = 0;
      mptr = 1'b0;
      bp_hold = 0;
      repeat (2) @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      #2;
      rst = 1'b1;
      repeat (6) step(1'b0);
      set_op(1, 32'd3, 32'd4, 5'h09, 4'hD);
      set_op(0, 32'd8, 32'd8, 5'h08, 4'hE);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one registered ALU instance (1-cycle latency, 5-bit op select, Zero = A==B) between two requesters, e.g. the EX stage and a multi-cycle helper unit.
- Accepts one operation at a time through valid/ready handshakes with round-robin arbitration.
- Sequences the operands into the ALU and captures the result.
- Returns the result with requester ID, tag, zero and error flags through a valid/ready response channel.

Parameters:
- WIDTH, 32, operand/result width.
- TAGW, 4, width of the requester-supplied tag echoed in the response.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req0_sel  input  5  requester 0 ALU op code.
- req0_tag  input  TAGW  requester 0 tag.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel, req1_tag  as requester 0, for requester 1.
- alu_a, alu_b  output  WIDTH  operands driven to the ALU.
- alu_sel  output  5  op code driven to the ALU.
- alu_result  input  WIDTH  ALU registered result.
- alu_zero  input  1  ALU registered Zero flag.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer takes the response.
- resp_id  output  1  index of the requester served.
- resp_tag  output  TAGW  echoed tag.
- resp_data  output  WIDTH  result.
- resp_zero  output  1  captured alu_zero.
- resp_err  output  1  operation rejected, not executed.

Behaviour:
- **States:** IDLE, EXEC, CAPT, RESP. One operation in flight at a time.
- **Reset (rst=0, asynchronous):**
  - state=IDLE; round-robin pointer=0.
  - All outputs 0: req*_ready, alu_a/b/sel, resp_valid, resp_id, resp_tag, resp_data, resp_zero, resp_err.
  - Reset mid-operation discards the in-flight operation and any pending response.
- **IDLE arbitration:**
  - Only one valid: that requester wins.
  - Both valid: the requester equal to the pointer wins.
  - The winner's req_ready=1, combinationally from the valids. Accept = valid&ready at the edge.
  - req*_ready=0 in all states other than IDLE.
- **On accept:**
  - Latch a, b, sel, tag and winner id into internal registers.
  - Pointer := other requester.
  - alu_a/alu_b/alu_sel are driven from the latched registers and held until the next accept.
- **Legal op codes:** 0x00..0x10.
  - Illegal (sel > 0x10) → error.
  - Divide by zero (sel 0x04 or 0x05 with b==0) → error.
- **Error path:** on accept, next state RESP directly; resp_err=1, resp_data=0, resp_zero=0. alu_* still updated but result unused.
- **Normal path:**
  - IDLE → EXEC on accept. The ALU samples the operands at the end of EXEC.
  - EXEC → CAPT unconditionally.
  - In CAPT, alu_result/alu_zero are valid. Register them into resp_data/resp_zero at the end of CAPT, with resp_err=0.
  - CAPT → RESP.
- **Latency:** resp_valid rises 3 cycles after the accept edge (normal path), 1 cycle after it (error path).
- **RESP:**
  - resp_valid=1; all resp_* fields stable while resp_valid=1 and resp_ready=0.
  - On resp_valid&resp_ready: resp_valid→0, state → IDLE.
  - No new accept in the same cycle; the earliest next accept is the cycle after returning to IDLE.
- **resp_ready:** ignored outside RESP.
- **Requesters:** may change inputs freely while not ready. Dropping valid before acceptance is allowed and simply withdraws the request.
- **Zero semantics:** resp_zero reflects the ALU's A==B flag for the captured operands, not result==0.

Test Plan:
- **Add:** req0 a=5, b=7, sel=0x06, tag=3; resp_ready=1 → accept cycle 0; resp_valid at cycle 3 with data=12, zero=0, id=0, tag=3, err=0; IDLE at cycle 4.
- **Contention:** req0 and req1 both valid from reset with ops (10-4, sel 0x08) and (6 AND 3, sel 0x0A) → req0 served first (data 6), then req1 (data 2). Re-asserting both afterwards grants req0 again only after req1 was served (alternation over 4 ops: 0,1,0,1).
- **Divide by zero:** req1 a=9, b=0, sel=0x04 → resp_valid 1 cycle after accept, err=1, data=0. Same with b=3 → data=3, err=0, 3-cycle latency.
- **Illegal op and Zero flag:** sel=0x11 → err=1, data=0. sel=0x0E (slt) with a=0xFFFFFFFF, b=1 → data=1. a=b=0x55 with sel=0x0B → zero=1, data=0x55.
- **Backpressure:** resp_ready=0 for 5 cycles in RESP → resp_* stable, req*_ready stays 0 despite pending req1_valid; resp_ready=1 → handshake, then req1 accepted the cycle after IDLE is re-entered.
- **Reset mid-op:** assert rst=0 asynchronously during EXEC → all outputs 0 immediately, no response after release; first post-reset contention grants req0.
